// File: rtl/button_pkg.sv
// Shared types and helpers for the multi-channel push-button debouncer.
package button_pkg;

    localparam int CLK_FREQ_HZ = 50_000_000;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } debounce_state_t;

    // The counter only has to reach cycles-1, so clog2(cycles) bits are enough.
    function automatic int count_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One debounce lane: 2-flop synchronizer, stability counter and press/release FSM.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int            CW         = count_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic          IDLE_LEVEL = ACTIVE_LOW;

    logic            sync_meta;
    logic            sync_out;
    logic            sample;
    debounce_state_t state_q;
    debounce_state_t state_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            pressed_d;
    logic            press_pulse_d;
    logic            release_pulse_d;

    // Reset to the idle pin level so deassertion never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= IDLE_LEVEL;
            sync_out  <= IDLE_LEVEL;
        end else begin
            sync_meta <= button;
            sync_out  <= sync_meta;
        end
    end

    assign sample = ACTIVE_LOW ? ~sync_out : sync_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RELEASED;
            count_q       <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            pressed       <= pressed_d;
            press_pulse   <= press_pulse_d;
            release_pulse <= release_pulse_d;
        end
    end

    // Entering a confirm state counts as the first stable sample.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        pressed_d       = pressed;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (sample) begin
                    state_d = CONFIRM_PRESS;
                    count_d = ONE;
                end else begin
                    count_d = '0;
                end
            end
            CONFIRM_PRESS: begin
                if (!sample) begin
                    state_d = RELEASED;
                    count_d = '0;
                end else if (count_q == LAST_COUNT) begin
                    state_d       = PRESSED;
                    count_d       = '0;
                    pressed_d     = 1'b1;
                    press_pulse_d = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            PRESSED: begin
                if (!sample) begin
                    state_d = CONFIRM_RELEASE;
                    count_d = ONE;
                end else begin
                    count_d = '0;
                end
            end
            CONFIRM_RELEASE: begin
                if (sample) begin
                    state_d = PRESSED;
                    count_d = '0;
                end else if (count_q == LAST_COUNT) begin
                    state_d         = RELEASED;
                    count_d         = '0;
                    pressed_d       = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            default: begin
                state_d   = RELEASED;
                count_d   = '0;
                pressed_d = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/button_debounce.sv
// N independent debounce lanes plus per-button toggle registers for LED drive.
module button_debounce
    import button_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N:1]   Button,
    output logic [N:1]   Pressed,
    output logic [N:1]   Press_Pulse,
    output logic [N:1]   Release_Pulse,
    output logic [N:1]   Toggle
);

    for (genvar n = 1; n <= N; n++) begin : g_channel
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_channel (
            .clk           (Clk),
            .rst           (Reset),
            .button        (Button[n]),
            .pressed       (Pressed[n]),
            .press_pulse   (Press_Pulse[n]),
            .release_pulse (Release_Pulse[n])
        );
    end

    // Flips the cycle after each registered press strobe; releases are ignored.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Toggle <= '0;
        end else begin
            Toggle <= Toggle ^ Press_Pulse;
        end
    end

endmodule
